// File: rtl/hilo_pkg.sv
// hilo_pkg: op codes, FSM state encoding and divide step count shared by the
// HI/LO multiply/divide sequencer and its divide datapath.
// Also holds a small helper to classify legal HI/LO op codes.
package hilo_pkg;

   // Op codes presented by the execute stage (0 and 7 are ignored)
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   // Sequencer states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MUL   = 2'd1;
   localparam logic [1:0] ST_DIV   = 2'd2;
   localparam logic [1:0] ST_WRITE = 2'd3;

   localparam int DIV_STEPS = 32;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op >= OP_MULT) && (op <= OP_MTLO);
   endfunction

endpackage

// File: rtl/hilo_div_core.sv
// hilo_div_core: unsigned 32/32 restoring divider, one quotient bit per step.
// Latency: DIV_STEPS step_en cycles after start; done pulses with the last step.
// Backpressure: none; the owner simply withholds step_en to pause or abandon.
// Ports: Clk/Rst (sync, active-high); start loads dividend/divisor magnitudes
// and clears the step counter; step_en runs one step; done marks the final
// step; quotient/remainder are the register contents after the current step.
import hilo_pkg::*;

module hilo_div_core (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        start,
   input  logic        step_en,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [63:0] rem_quo;       // {partial remainder, dividend/quotient bits}
   logic [31:0] divisor_q;
   logic [4:0]  cnt;
   logic [32:0] rem_shift;     // remainder after shifting in the next dividend bit
   logic [33:0] diff;          // extra MSB is the borrow of the trial subtract
   logic [63:0] rem_quo_next;

   assign rem_shift = rem_quo[63:31];
   assign diff      = {1'b0, rem_shift} - {2'b00, divisor_q};

   // Remainder never exceeds the divisor, so the restored difference fits in 32 bits
   assign rem_quo_next = diff[33] ? {rem_quo[62:0], 1'b0}
                                  : {diff[31:0], rem_quo[30:0], 1'b1};

   assign done      = step_en && (cnt == 5'(DIV_STEPS - 1));
   assign quotient  = rem_quo_next[31:0];
   assign remainder = rem_quo_next[63:32];

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rem_quo   <= '0;
         divisor_q <= '0;
         cnt       <= '0;
      end else if (start) begin
         rem_quo   <= {32'd0, dividend};
         divisor_q <= divisor;
         cnt       <= '0;
      end else if (step_en) begin
         rem_quo   <= rem_quo_next;
         cnt       <= cnt + 5'd1;
      end
   end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: multiply/divide sequencer owning every HI/LO register write.
// Latency: W_en in cycle 1 (MTHI/MTLO/div-by-0), 2 (MULT*), 33 (DIV*) after accept.
// Backpressure: while Busy, any new op or MFHI/MFLO read is held via Stall.
// Ports: Clk/Rst (sync, active-high); Op_valid/Op/Src_a/Src_b op request;
// Cancel aborts in-flight work; Hilo_read flags a decode-stage MFHI/MFLO;
// Hi_cur/Lo_cur feed the untouched half on MTHI/MTLO; Busy/Stall pipeline
// status; W_en single-cycle write strobe with registered High/Low data.
import hilo_pkg::*;

module hilo_mdu_ctrl (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Op_valid,
   input  logic [2:0]  Op,
   input  logic [31:0] Src_a,
   input  logic [31:0] Src_b,
   input  logic        Cancel,
   input  logic        Hilo_read,
   input  logic [31:0] Hi_cur,
   input  logic [31:0] Lo_cur,
   output logic        Busy,
   output logic        Stall,
   output logic        W_en,
   output logic [31:0] High,
   output logic [31:0] Low
);

   logic [1:0]  state;
   logic [31:0] op_a, op_b;
   logic        mul_signed, sign_q, sign_r;

   logic        accept, is_mul, is_div, div_signed, div_zero;
   logic [31:0] a_mag, b_mag;
   logic        div_start, div_step, div_done;
   logic [31:0] div_quo, div_rem;
   logic signed [65:0] product;

   assign accept     = Op_valid && !Cancel && (state == ST_IDLE) && is_legal_op(Op);
   assign is_mul     = (Op == OP_MULT) || (Op == OP_MULTU);
   assign is_div     = (Op == OP_DIV)  || (Op == OP_DIVU);
   assign div_signed = (Op == OP_DIV);
   assign div_zero   = (Src_b == 32'd0);

   assign a_mag = (div_signed && Src_a[31]) ? (~Src_a + 32'd1) : Src_a;
   assign b_mag = (div_signed && Src_b[31]) ? (~Src_b + 32'd1) : Src_b;

   assign div_start = accept && is_div && !div_zero;
   assign div_step  = (state == ST_DIV) && !Cancel;

   // One extra operand bit makes a single signed multiply cover MULT and MULTU
   assign product = $signed({mul_signed & op_a[31], op_a}) *
                    $signed({mul_signed & op_b[31], op_b});

   assign Busy  = (state != ST_IDLE);
   assign Stall = Busy && (Op_valid || Hilo_read);
   assign W_en  = (state == ST_WRITE) && !Cancel;

   hilo_div_core u_div (
      .Clk       (Clk),
      .Rst       (Rst),
      .start     (div_start),
      .step_en   (div_step),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= ST_IDLE;
         High       <= '0;
         Low        <= '0;
         op_a       <= '0;
         op_b       <= '0;
         mul_signed <= 1'b0;
         sign_q     <= 1'b0;
         sign_r     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_a       <= Src_a;
                  op_b       <= Src_b;
                  mul_signed <= (Op == OP_MULT);
                  sign_q     <= div_signed && (Src_a[31] ^ Src_b[31]);
                  sign_r     <= div_signed && Src_a[31];
                  if (is_mul) begin
                     state <= ST_MUL;
                  end else if (is_div) begin
                     if (div_zero) begin
                        High  <= Src_a;
                        Low   <= 32'hFFFF_FFFF;
                        state <= ST_WRITE;
                     end else begin
                        state <= ST_DIV;
                     end
                  end else if (Op == OP_MTHI) begin
                     High  <= Src_a;
                     Low   <= Lo_cur;
                     state <= ST_WRITE;
                  end else begin
                     High  <= Hi_cur;
                     Low   <= Src_a;
                     state <= ST_WRITE;
                  end
               end
            end
            ST_MUL: begin
               if (Cancel) begin
                  state <= ST_IDLE;
               end else begin
                  {High, Low} <= product[63:0];
                  state       <= ST_WRITE;
               end
            end
            ST_DIV: begin
               if (Cancel) begin
                  state <= ST_IDLE;
               end else if (div_done) begin
                  Low   <= sign_q ? (~div_quo + 32'd1) : div_quo;
                  High  <= sign_r ? (~div_rem + 32'd1) : div_rem;
                  state <= ST_WRITE;
               end
            end
            default: state <= ST_IDLE;   // WRITE lasts exactly one cycle
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl: directed vectors for the HI/LO sequencer; expected writes
// go into a scoreboard queue and a negedge monitor checks every W_en pulse.
// Timing: inputs change 1ns after posedge, outputs sampled on negedge.
import hilo_pkg::*;

module tb_hilo_mdu_ctrl;

   logic        Clk = 1'b0;
   logic        Rst, Op_valid, Cancel, Hilo_read;
   logic [2:0]  Op;
   logic [31:0] Src_a, Src_b, Hi_cur, Lo_cur;
   logic        Busy, Stall, W_en;
   logic [31:0] High, Low;

   typedef struct {
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   tests  = 0;
   int   fails  = 0;
   int   c0;

   hilo_mdu_ctrl dut (
      .Clk(Clk), .Rst(Rst), .Op_valid(Op_valid), .Op(Op), .Src_a(Src_a),
      .Src_b(Src_b), .Cancel(Cancel), .Hilo_read(Hilo_read), .Hi_cur(Hi_cur),
      .Lo_cur(Lo_cur), .Busy(Busy), .Stall(Stall), .W_en(W_en), .High(High),
      .Low(Low)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every write strobe must match the oldest expectation
   always @(negedge Clk) begin
      if (W_en === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_wen", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wen_cycle", 32'(cyc), 32'(e.cyc));
            chk("high", High, e.hi);
            chk("low", Low, e.lo);
         end
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      Op_valid = 1'b1;
      Op       = op;
      Src_a    = a;
      Src_b    = b;
      c0       = cyc;
   endtask

   task automatic expect_wr(input int lat, input logic [31:0] hi, input logic [31:0] lo);
      exp_t e;
      e.cyc = c0 + lat;
      e.hi  = hi;
      e.lo  = lo;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge Clk);
         if (!Busy) return;
      end
      chk("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      Rst = 1'b1; Op_valid = 1'b0; Op = '0; Src_a = '0; Src_b = '0;
      Cancel = 1'b0; Hilo_read = 1'b0; Hi_cur = '0; Lo_cur = '0;
      step(); step();
      Rst = 1'b0;
      @(negedge Clk);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_stall", 32'(Stall), 32'd0);
      chk("rst_wen", 32'(W_en), 32'd0);
      chk("rst_high", High, 32'd0);
      chk("rst_low", Low, 32'd0);

      // MULTU max x max
      step(); issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      expect_wr(2, 32'hFFFF_FFFE, 32'h0000_0001);
      step(); Op_valid = 1'b0;
      wait_idle(10);

      // MULT -3 x 5 with a second op held during MUL and WRITE
      step(); issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
      expect_wr(2, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      step(); Op = OP_MTHI; Src_a = 32'h1;
      @(negedge Clk); chk("mul_stall", 32'(Stall), 32'd1);
      step();
      @(negedge Clk); chk("write_stall", 32'(Stall), 32'd1);
      step(); Op_valid = 1'b0;
      wait_idle(10);

      // DIV -7 / 2 with MFHI/MFLO pending throughout
      step(); issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      expect_wr(33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      for (int k = 1; k <= 33; k++) begin
         step(); Op_valid = 1'b0; Hilo_read = 1'b1;
         @(negedge Clk); chk("div_read_stall", 32'(Stall), 32'd1);
      end
      step();
      @(negedge Clk);
      chk("post_div_stall", 32'(Stall), 32'd0);
      chk("post_div_busy", 32'(Busy), 32'd0);
      Hilo_read = 1'b0;

      // DIVU by zero
      step(); issue(OP_DIVU, 32'h0000_1234, 32'd0);
      expect_wr(1, 32'h0000_1234, 32'hFFFF_FFFF);
      step(); Op_valid = 1'b0;
      wait_idle(10);

      // MTHI then MTLO held back-to-back; MTLO accepted in first IDLE cycle
      step(); Hi_cur = 32'h0000_2222; Lo_cur = 32'h0000_5555;
      issue(OP_MTHI, 32'h0000_AAAA, 32'd0);
      expect_wr(1, 32'h0000_AAAA, 32'h0000_5555);
      expect_wr(3, 32'h0000_2222, 32'h0000_1111);
      step(); Op = OP_MTLO; Src_a = 32'h0000_1111;
      @(negedge Clk); chk("b2b_stall", 32'(Stall), 32'd1);
      step(); step(); Op_valid = 1'b0;
      wait_idle(10);

      // Signed overflow and an ordinary DIVU
      step(); issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      expect_wr(33, 32'h0000_0000, 32'h8000_0000);
      step(); Op_valid = 1'b0;
      wait_idle(50);
      step(); issue(OP_DIVU, 32'd100, 32'd7);
      expect_wr(33, 32'd2, 32'd14);
      step(); Op_valid = 1'b0;
      wait_idle(50);

      // Illegal op and Cancel-in-IDLE are not accepted
      step(); issue(3'd7, 32'd1, 32'd1);
      step(); Op_valid = 1'b0;
      @(negedge Clk); chk("illegal_op_busy", 32'(Busy), 32'd0);
      step(); issue(OP_MTHI, 32'd9, 32'd0); Cancel = 1'b1;
      step(); Op_valid = 1'b0; Cancel = 1'b0;
      @(negedge Clk); chk("cancel_idle_busy", 32'(Busy), 32'd0);

      // Cancel during WRITE suppresses the strobe
      step(); issue(OP_MULT, 32'd2, 32'd3);
      step(); Op_valid = 1'b0;
      step(); Cancel = 1'b1;
      @(negedge Clk); chk("cancel_write_wen", 32'(W_en), 32'd0);
      step(); Cancel = 1'b0;
      @(negedge Clk); chk("cancel_write_busy", 32'(Busy), 32'd0);

      // Cancel in DIV cycle 10
      step(); issue(OP_DIVU, 32'd1000, 32'd3);
      step(); Op_valid = 1'b0;
      for (int k = 2; k <= 10; k++) step();
      Cancel = 1'b1;
      step(); Cancel = 1'b0;
      @(negedge Clk); chk("cancel_div_busy", 32'(Busy), 32'd0);

      // Reset in DIV cycle 10 (High/Low currently nonzero)
      step(); issue(OP_DIV, 32'h0000_4000, 32'd5);
      step(); Op_valid = 1'b0;
      for (int k = 2; k <= 10; k++) step();
      Rst = 1'b1;
      step(); Rst = 1'b0;
      @(negedge Clk);
      chk("rst_div_busy", 32'(Busy), 32'd0);
      chk("rst_div_high", High, 32'd0);
      chk("rst_div_low", Low, 32'd0);

      repeat (40) step();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
